// File: rtl/ap_ctrl_sampler_if.sv
// Observation and record-drain bus for ap_ctrl_sampler.
// AP_STALL_CNT_EN adds the rec_stall field to the record port.
interface ap_ctrl_sampler_if #(
  parameter int CNT_W = 32,
  parameter int TAG_W = 8
);
  logic             ap_start;
  logic             ap_done;
  logic             ap_continue;
  logic             finish;
  // Record port: a record transfers on any cycle with rec_valid & rec_ready;
  // rec_* stay stable while rec_valid=1 and rec_ready=0.
  logic             rec_valid;
  logic             rec_ready;
  logic [TAG_W-1:0] rec_tag;
  logic [CNT_W-1:0] rec_latency;
  logic [CNT_W-1:0] rec_ii;
`ifdef AP_STALL_CNT_EN
  logic [CNT_W-1:0] rec_stall;

  modport slave (
    input  ap_start, ap_done, ap_continue, finish, rec_ready,
    output rec_valid, rec_tag, rec_latency, rec_ii, rec_stall
  );
  modport master (
    output ap_start, ap_done, ap_continue, finish, rec_ready,
    input  rec_valid, rec_tag, rec_latency, rec_ii, rec_stall
  );
`else
  modport slave (
    input  ap_start, ap_done, ap_continue, finish, rec_ready,
    output rec_valid, rec_tag, rec_latency, rec_ii
  );
  modport master (
    output ap_start, ap_done, ap_continue, finish, rec_ready,
    input  rec_valid, rec_tag, rec_latency, rec_ii
  );
`endif
endinterface

// File: rtl/ap_ctrl_sampler.sv
// Passive ap_ctrl_hs transaction sampler: per-transaction tag/latency/II records in a FWFT FIFO.
// Optional macro AP_STALL_CNT_EN adds a per-record count of done-but-not-continued cycles.
module ap_ctrl_sampler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32,
  parameter int TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  ap_ctrl_sampler_if.slave bus,
  output logic [CNT_W-1:0] txn_count,
  output logic             overflow,
  output logic             busy,
  output logic             drained,
  output logic [1:0]       fsm_state
);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef AP_STALL_CNT_EN
  localparam int REC_W = TAG_W + 3 * CNT_W;
`else
  localparam int REC_W = TAG_W + 2 * CNT_W;
`endif
  localparam logic [CNT_W-1:0] ZERO_CNT = '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] start_cyc;
  logic [CNT_W-1:0] prev_start;
  logic [CNT_W-1:0] ii_q;
  logic             first;
  logic             finish_seen;
  logic [TAG_W-1:0] tag;
`ifdef AP_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;
`endif

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W-1:0] head_idx;
  logic [REC_W-1:0] rec_in;

  logic             fin_now;
  logic             done_ok;
  logic             start_ok;
  logic [CNT_W-1:0] ii_now;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  logic             wr_en;

  assign fin_now  = finish_seen | bus.finish;
  assign done_ok  = bus.ap_done & bus.ap_continue;
  assign start_ok = (state == S_IDLE) & bus.ap_start & ~fin_now;
  assign ii_now   = first ? ZERO_CNT : cyc - prev_start;
  assign push     = (start_ok & done_ok) | ((state == S_RUN) & done_ok);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = ~empty & bus.rec_ready;
  assign wr_en = push & (~full | pop);

  always_comb begin
    rec_in = '0;
    if (state == S_RUN) begin
`ifdef AP_STALL_CNT_EN
      rec_in = {tag, cyc - start_cyc, ii_q, stall_q};
`else
      rec_in = {tag, cyc - start_cyc, ii_q};
`endif
    end else begin
`ifdef AP_STALL_CNT_EN
      rec_in = {tag, ZERO_CNT, ii_now, ZERO_CNT};
`else
      rec_in = {tag, ZERO_CNT, ii_now};
`endif
    end
  end

  // When empty, point at the most recently popped slot so rec_* keep their last value.
  assign head_idx = empty ? (rd_ptr[PTR_W-1:0] - 1'b1) : rd_ptr[PTR_W-1:0];

  assign bus.rec_valid = ~empty;
`ifdef AP_STALL_CNT_EN
  assign {bus.rec_tag, bus.rec_latency, bus.rec_ii, bus.rec_stall} = mem[head_idx];
`else
  assign {bus.rec_tag, bus.rec_latency, bus.rec_ii} = mem[head_idx];
`endif

  assign busy      = (state == S_RUN);
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cyc         <= '0;
      start_cyc   <= '0;
      prev_start  <= '0;
      ii_q        <= '0;
      first       <= 1'b1;
      finish_seen <= 1'b0;
      tag         <= '0;
      txn_count   <= '0;
      overflow    <= 1'b0;
      drained     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
`ifdef AP_STALL_CNT_EN
      stall_q     <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cyc         <= cyc + 1'b1;
      finish_seen <= fin_now;
      drained     <= (state == S_FIN) & empty;

      case (state)
        S_IDLE: begin
          if (fin_now) begin
            state <= S_FIN;
          end else if (bus.ap_start) begin
            start_cyc  <= cyc;
            ii_q       <= ii_now;
            prev_start <= cyc;
            first      <= 1'b0;
`ifdef AP_STALL_CNT_EN
            stall_q    <= '0;
`endif
            if (!done_ok) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (done_ok) begin
            state <= fin_now ? S_FIN : S_IDLE;
          end
`ifdef AP_STALL_CNT_EN
          else if (bus.ap_done) begin
            stall_q <= stall_q + 1'b1;
          end
`endif
        end
        S_FIN:   state <= S_FIN;
        default: state <= S_IDLE;
      endcase

      // Tag and count advance on every completion, stored or dropped.
      if (push) begin
        tag       <= tag + 1'b1;
        txn_count <= txn_count + 1'b1;
        if (wr_en) begin
          mem[wr_ptr[PTR_W-1:0]] <= rec_in;
          wr_ptr                 <= wr_ptr + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_ap_ctrl_sampler.sv
// Directed self-checking bench for ap_ctrl_sampler (default DEPTH=4, CNT_W=32, TAG_W=8).
module tb_ap_ctrl_sampler;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;
  localparam int TAG_W = 8;
  localparam int REC_W = TAG_W + 3 * CNT_W;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ap_ctrl_sampler_if #(.CNT_W(CNT_W), .TAG_W(TAG_W)) bus ();
  logic [CNT_W-1:0] txn_count;
  logic             overflow;
  logic             busy;
  logic             drained;
  logic [1:0]       fsm_state;

  ap_ctrl_sampler #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .txn_count (txn_count),
    .overflow  (overflow),
    .busy      (busy),
    .drained   (drained),
    .fsm_state (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];

  function automatic logic [REC_W-1:0] pack_rec(int tag, int lat, int ii, int stall);
    logic [31:0]      tv;
    logic [CNT_W-1:0] lv, iv, sv;
    tv = tag;
    lv = lat;
    iv = ii;
    sv = stall;
`ifndef AP_STALL_CNT_EN
    sv = '0;
`endif
    return {tv[TAG_W-1:0], lv, iv, sv};
  endfunction

  // scoreboard collector: every accepted record, sampled mid-cycle
  always @(negedge clock) begin
    if (!reset && bus.rec_valid && bus.rec_ready) begin
`ifdef AP_STALL_CNT_EN
      got_q.push_back({bus.rec_tag, bus.rec_latency, bus.rec_ii, bus.rec_stall});
`else
      got_q.push_back({bus.rec_tag, bus.rec_latency, bus.rec_ii, {CNT_W{1'b0}}});
`endif
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.ap_start    = 1'b0;
    bus.ap_done     = 1'b0;
    bus.ap_continue = 1'b1;
    bus.finish      = 1'b0;
    bus.rec_ready   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  // lat = total start-to-done cycles; the last `stall` of them hold done with continue low.
  task automatic run_txn(input int lat, input int stall, input bit pop_at_done);
    if (lat == 0) begin
      bus.ap_start = 1'b1;
      bus.ap_done  = 1'b1;
      if (pop_at_done) bus.rec_ready = 1'b1;
      tick();
      bus.ap_start = 1'b0;
      bus.ap_done  = 1'b0;
      if (pop_at_done) bus.rec_ready = 1'b0;
    end else begin
      bus.ap_start = 1'b1;
      tick();
      bus.ap_start = 1'b0;
      repeat (lat - stall - 1) tick();
      bus.ap_done = 1'b1;
      if (stall > 0) begin
        bus.ap_continue = 1'b0;
        repeat (stall) tick();
        bus.ap_continue = 1'b1;
      end
      if (pop_at_done) bus.rec_ready = 1'b1;
      tick();
      bus.ap_done = 1'b0;
      if (pop_at_done) bus.rec_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.ap_start    = 1'b0;
    bus.ap_done     = 1'b0;
    bus.ap_continue = 1'b1;
    bus.finish      = 1'b0;
    bus.rec_ready   = 1'b1;
    repeat (2) tick();
    checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.rec_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained: got %b want 0", drained); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (txn_count !== 0) begin errors++; $display("FAIL reset_txn_count: got %0d want 0", txn_count); end
    checks++; if (bus.rec_tag !== 0 || bus.rec_latency !== 0 || bus.rec_ii !== 0) begin
      errors++; $display("FAIL reset_rec: got tag %0d lat %0d ii %0d want 0 0 0", bus.rec_tag, bus.rec_latency, bus.rec_ii);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    repeat (10) tick();
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    repeat (7) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    repeat (7) tick();
    bus.ap_done = 1'b1;
    checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", bus.rec_valid); end
    tick();
    bus.ap_done = 1'b0;
    checks++; if (bus.rec_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.rec_valid); end
    checks++; if (bus.rec_tag !== 0) begin errors++; $display("FAIL single_tag: got %0d want 0", bus.rec_tag); end
    checks++; if (bus.rec_latency !== 15) begin errors++; $display("FAIL single_latency: got %0d want 15", bus.rec_latency); end
    checks++; if (bus.rec_ii !== 0) begin errors++; $display("FAIL single_ii: got %0d want 0", bus.rec_ii); end
    checks++; if (txn_count !== 1) begin errors++; $display("FAIL single_txn_count: got %0d want 1", txn_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b want 0", busy); end
    tick();
    checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", bus.rec_valid); end
    checks++; if (bus.rec_latency !== 15) begin errors++; $display("FAIL single_hold_empty: got %0d want 15", bus.rec_latency); end
    got_q.delete();
  endtask

  task automatic test_ii();
    do_reset();
    run_txn(8, 0, 1'b0);
    repeat (21) tick();
    run_txn(8, 0, 1'b0);
    repeat (21) tick();
    run_txn(8, 0, 1'b0);
    exp_q.push_back(pack_rec(0, 8, 0, 0));
    exp_q.push_back(pack_rec(1, 8, 30, 0));
    exp_q.push_back(pack_rec(2, 8, 30, 0));
    for (int i = 0; i < 30 && got_q.size() < exp_q.size(); i++) tick();
    repeat (2) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ii_count: got %0d records want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ii_rec%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (txn_count !== 3) begin errors++; $display("FAIL ii_txn_count: got %0d want 3", txn_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.rec_ready = 1'b0;
    repeat (4) run_txn(2, 0, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
    repeat (2) run_txn(2, 0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (txn_count !== 6) begin errors++; $display("FAIL ovf_txn_count: got %0d want 6", txn_count); end
    checks++; if (bus.rec_valid !== 1'b1 || bus.rec_tag !== 0) begin
      errors++; $display("FAIL ovf_head: got valid %b tag %0d want 1 0", bus.rec_valid, bus.rec_tag);
    end
    tick();
    checks++; if (bus.rec_tag !== 0 || bus.rec_latency !== 2) begin
      errors++; $display("FAIL ovf_hold: got tag %0d lat %0d want 0 2", bus.rec_tag, bus.rec_latency);
    end
    for (int t = 0; t < 4; t++) exp_q.push_back(pack_rec(t, 2, (t == 0) ? 0 : 3, 0));
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 30 && got_q.size() < exp_q.size(); i++) tick();
    repeat (3) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d records want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_rec%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    bus.rec_ready = 1'b0;
    repeat (4) run_txn(2, 0, 1'b0);
    run_txn(2, 0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
    checks++; if (txn_count !== 5) begin errors++; $display("FAIL fullpop_txn_count: got %0d want 5", txn_count); end
    checks++; if (bus.rec_tag !== 1) begin errors++; $display("FAIL fullpop_head: got tag %0d want 1", bus.rec_tag); end
    for (int t = 0; t < 5; t++) exp_q.push_back(pack_rec(t, 2, (t == 0) ? 0 : 3, 0));
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 30 && got_q.size() < exp_q.size(); i++) tick();
    repeat (3) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fullpop_count: got %0d records want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpop_rec%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    run_txn(8, 3, 1'b0);
    run_txn(0, 0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_same_cycle_busy: got %b want 0", busy); end
    exp_q.push_back(pack_rec(0, 8, 0, 3));
    exp_q.push_back(pack_rec(1, 0, 9, 0));
    for (int i = 0; i < 30 && got_q.size() < exp_q.size(); i++) tick();
    repeat (2) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d records want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_rec%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_finish();
    do_reset();
    bus.rec_ready = 1'b0;
    bus.ap_start  = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    bus.finish   = 1'b1;
    tick();
    bus.finish = 1'b0;
    repeat (4) tick();
    bus.ap_done = 1'b1;
    tick();
    bus.ap_done  = 1'b0;
    bus.ap_start = 1'b1;
    repeat (3) tick();
    bus.ap_start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fin_busy: got %b want 0", busy); end
    checks++; if (txn_count !== 1) begin errors++; $display("FAIL fin_txn_count: got %0d want 1", txn_count); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL fin_drained_early: got %b want 0", drained); end
    exp_q.push_back(pack_rec(0, 6, 0, 0));
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 10 && !drained; i++) tick();
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL fin_drained: got %b want 1", drained); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fin_count: got %0d records want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fin_rec%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rec_ready = 1'b0;
    repeat (2) run_txn(2, 0, 1'b0);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || bus.rec_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_pre: got busy %b valid %b want 1 1", busy, bus.rec_valid);
    end
    reset = 1'b1;
    tick();
    checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus.rec_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (txn_count !== 0) begin errors++; $display("FAIL rmid_txn_count: got %0d want 0", txn_count); end
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    bus.rec_ready = 1'b1;
    run_txn(3, 0, 1'b0);
    exp_q.push_back(pack_rec(0, 3, 0, 0));
    for (int i = 0; i < 30 && got_q.size() < exp_q.size(); i++) tick();
    repeat (2) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count: got %0d records want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_rec%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ii();
    test_overflow();
    test_full_pop();
    test_stall();
    test_finish();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
